hmmm_prog_loader: RTL

- Serial program loader that sits directly upstream of the hmmm core's instruction/data memory write port.
- Samples a pad-driven serial clock and two serial lines, one carrying address bits and one carrying data bits, and assembles 8-bit address / 16-bit word frames.
- Issues one buffered memory write per frame using a valid/ready handshake.
- Holds the core in hold while loading, then emits a single start pulse when loading ends.

---
 rtl/hmmm_prog_loader.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/hmmm_prog_loader.sv
// Serial program loader for the hmmm core: assembles address/word frames from
// pad-driven serial lines and writes them into core memory over valid/ready.
module hmmm_prog_loader #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en_in,
  input  logic              sclk_in,
  input  logic              pgrm_addr_in,
  input  logic              pgrm_data_in,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              cpu_start,
  output logic [ADDR_W:0]   words_loaded,
  output logic              frame_err,
  output logic              overrun
);

  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN} state_t;

  localparam logic [4:0]    LAST_BIT = 5'(DATA_W - 1);
  localparam logic [4:0]    ADDR_LIM = 5'(ADDR_W);
  localparam logic [ADDR_W:0] WL_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] load_sync, sclk_sync, abit_sync, dbit_sync;
  logic load_s, sclk_s, abit_s, dbit_s;
  logic load_prev, sclk_prev;
  logic stb_p1, abit_p1, dbit_p1;
  logic load_rise;

  logic clear_all, drop_partial, shift_en;
  logic [4:0]        bit_cnt;
  logic [ADDR_W-1:0] addr_sr, addr_nxt;
  logic [DATA_W-1:0] data_sr, data_nxt;
  logic frame_done, xfer, accept;

  // Stage p0: pad synchronizers; all four lines share the same depth so the
  // data bits stay aligned with the synchronized serial clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_sync <= '0;
      sclk_sync <= '0;
      abit_sync <= '0;
      dbit_sync <= '0;
    end else begin
      load_sync <= {load_sync[SYNC_STAGES-2:0], load_en_in};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
      abit_sync <= {abit_sync[SYNC_STAGES-2:0], pgrm_addr_in};
      dbit_sync <= {dbit_sync[SYNC_STAGES-2:0], pgrm_data_in};
    end
  end

  assign load_s    = load_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign abit_s    = abit_sync[SYNC_STAGES-1];
  assign dbit_s    = dbit_sync[SYNC_STAGES-1];
  assign load_rise = load_s & ~load_prev;

  // Stage p1: registered bit strobe with its address/data bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_prev <= 1'b0;
      sclk_prev <= 1'b0;
      stb_p1    <= 1'b0;
      abit_p1   <= 1'b0;
      dbit_p1   <= 1'b0;
    end else begin
      load_prev <= load_s;
      sclk_prev <= sclk_s;
      stb_p1    <= sclk_s & ~sclk_prev;
      abit_p1   <= abit_s;
      dbit_p1   <= dbit_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    clear_all    = 1'b0;
    drop_partial = 1'b0;
    shift_en     = 1'b0;
    cpu_start    = 1'b0;
    unique case (state)
      IDLE: begin
        if (load_rise) begin
          state_nxt = SHIFT;
          clear_all = 1'b1;
        end
      end
      SHIFT: begin
        if (!load_s) begin
          state_nxt    = DRAIN;
          drop_partial = (bit_cnt != 5'd0);
        end else begin
          shift_en = stb_p1;
        end
      end
      DRAIN: begin
        if (!mem_valid) begin
          state_nxt = IDLE;
          cpu_start = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign frame_done = shift_en && (bit_cnt == LAST_BIT);
  assign addr_nxt   = (bit_cnt < ADDR_LIM) ? {addr_sr[ADDR_W-2:0], abit_p1} : addr_sr;
  assign data_nxt   = {data_sr[DATA_W-2:0], dbit_p1};
  assign xfer       = mem_valid & mem_ready;
  // A finished frame may take the buffer if it is empty or emptying this cycle.
  assign accept     = frame_done & (~mem_valid | mem_ready);

  // Stage p2: frame assembly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= 5'd0;
      addr_sr <= '0;
      data_sr <= '0;
    end else if (clear_all || drop_partial) begin
      bit_cnt <= 5'd0;
    end else if (frame_done) begin
      bit_cnt <= 5'd0;
      addr_sr <= addr_nxt;
      data_sr <= data_nxt;
    end else if (shift_en) begin
      bit_cnt <= bit_cnt + 5'd1;
      addr_sr <= addr_nxt;
      data_sr <= data_nxt;
    end
  end

  // Stage p3: single-entry write buffer and status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (accept) begin
      mem_valid <= 1'b1;
      mem_addr  <= addr_nxt;
      mem_wdata <= data_nxt;
    end else if (xfer) begin
      mem_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      words_loaded <= '0;
      frame_err    <= 1'b0;
      overrun      <= 1'b0;
    end else if (clear_all) begin
      words_loaded <= '0;
      frame_err    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (xfer && (words_loaded != WL_MAX)) words_loaded <= words_loaded + 1'b1;
      if (drop_partial) frame_err <= 1'b1;
      if (frame_done && mem_valid && !mem_ready) overrun <= 1'b1;
    end
  end

  assign cpu_hold = (state != IDLE) || mem_valid;

endmodule
